// File: rtl/enigma_pkg.sv
// Shared Enigma constants and helpers: rotor I, its inverse, reflector B,
// the fixed plugboard pairs (used only when ENIGMA_PLUGBOARD_EN is defined),
// the 5-bit letter type, the decoder state encoding and mod-26 arithmetic.
package enigma_pkg;

    localparam int LETTERS = 26;
    localparam int PLUG_N  = 3;

    typedef logic [4:0] letter_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_XLATE,
        ST_EMIT,
        ST_DONE
    } dec_state_e;

    // EKMFLGDQVZNTOWYHXUSPAIBRCJ
    localparam letter_t ROTOR_I [LETTERS] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
        5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };

    localparam letter_t ROTOR_I_INV [LETTERS] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21,
        5'd25, 5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23,
        5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
    };

    // YRUHQSLDPXNGOKMIEBFZCWVJAT
    localparam letter_t REFL_B [LETTERS] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15,
        5'd23, 5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,
        5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19
    };

    // A<->B, C<->D, E<->F
    localparam letter_t PLUG_PAIRS [PLUG_N][2] = '{
        '{5'd0, 5'd1}, '{5'd2, 5'd3}, '{5'd4, 5'd5}
    };

    // Widen before adding so the wrap is explicit rather than 5-bit overflow.
    function automatic letter_t mod26_add(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic letter_t mod26_sub(letter_t a, letter_t b);
        logic [5:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + 6'd26 - {1'b0, b};
        return s[4:0];
    endfunction

endpackage

// File: rtl/enigma_stream_decoder_if.sv
// Key/go capture and plaintext stream signals of enigma_stream_decoder.
// master: operator/consumer side; slave: the decoder.
interface enigma_stream_decoder_if #(
    parameter int DEPTH = 16,
    parameter int CW    = 8
);
    logic [CW-1:0]         char_in;
    logic                  key_press;
    logic                  go;
    logic [4:0]            rotor_start;
    logic [CW-1:0]         char_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;
    logic                  bad_char;

    modport master (
        output char_in, key_press, go, rotor_start, out_ready,
        input  char_out, out_valid, busy, done, count, overflow, bad_char
    );

    modport slave (
        input  char_in, key_press, go, rotor_start, out_ready,
        output char_out, out_valid, busy, done, count, overflow, bad_char
    );
endinterface

// File: rtl/enigma_letter_path.sv
// Combinational single-rotor + reflector B Enigma letter path (x, p -> out).
// Self-inverse, so it serves both encrypt and decrypt. Defining
// ENIGMA_PLUGBOARD_EN wraps the path in the fixed PLUG_PAIRS swap.
module enigma_letter_path
    import enigma_pkg::*;
(
    input  letter_t x,
    input  letter_t p,
    output letter_t out
);

`ifdef ENIGMA_PLUGBOARD_EN
    function automatic letter_t plug(letter_t c);
        letter_t r;
        r = c;
        for (int unsigned i = 0; i < PLUG_N; i++) begin
            if (c == PLUG_PAIRS[i][0])      r = PLUG_PAIRS[i][1];
            else if (c == PLUG_PAIRS[i][1]) r = PLUG_PAIRS[i][0];
        end
        return r;
    endfunction
`endif

    letter_t x_in, a, b, d, e, f, g, o;

    // Forward through the rotor, reflect, back through the rotor inverse.
    always_comb begin
`ifdef ENIGMA_PLUGBOARD_EN
        x_in = plug(x);
`else
        x_in = x;
`endif
        a = mod26_add(x_in, p);
        b = ROTOR_I[a];
        d = mod26_sub(b, p);
        e = REFL_B[d];
        f = mod26_add(e, p);
        g = ROTOR_I_INV[f];
        o = mod26_sub(g, p);
`ifdef ENIGMA_PLUGBOARD_EN
        out = plug(o);
`else
        out = o;
`endif
    end

endmodule

// File: rtl/enigma_stream_decoder.sv
// Ciphertext buffer + replay decoder. Key rising edges fill a DEPTH-entry
// FIFO while idle; a go rising edge replays it through enigma_letter_path,
// stepping the rotor before each letter, and streams plaintext out on a
// valid/ready port. Optional plugboard: ENIGMA_PLUGBOARD_EN.
module enigma_stream_decoder
    import enigma_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    enigma_stream_decoder_if.slave  bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    dec_state_e state_q, state_d;

    letter_t          mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNTW-1:0]  count_q;
    letter_t          pos_q, head_q, path_out;
    logic             key_prev, go_prev;
    logic             key_rise, go_rise;
    logic             overflow_q, bad_q, busy_q, done_q, valid_q;
    logic [CW-1:0]    char_q;

    logic start, wr_en, wr_bad, wr_full, fetch, pop, ack, finish;
    logic buf_full, char_ok;

    assign key_rise = bus.key_press & ~key_prev;
    assign go_rise  = bus.go & ~go_prev;
    assign buf_full = (count_q == CNTW'(DEPTH));
    assign char_ok  = (bus.char_in <= CW'(LETTERS - 1));

    enigma_letter_path u_path (
        .x   (head_q),
        .p   (pos_q),
        .out (path_out)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_bad  = 1'b0;
        wr_full = 1'b0;
        fetch   = 1'b0;
        pop     = 1'b0;
        ack     = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A go edge wins over a same-cycle key edge so the letter
                // cannot land behind a decode that has already sized itself.
                if (go_rise) begin
                    start   = 1'b1;
                    state_d = (count_q == '0) ? ST_DONE : ST_FETCH;
                end else if (key_rise) begin
                    if (!char_ok)      wr_bad  = 1'b1;
                    else if (buf_full) wr_full = 1'b1;
                    else               wr_en   = 1'b1;
                end
            end
            ST_FETCH: begin
                fetch   = 1'b1;
                state_d = ST_XLATE;
            end
            ST_XLATE: begin
                pop     = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    ack     = 1'b1;
                    state_d = (count_q != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge-detect history; previous level resets high so a held key is ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_prev <= 1'b1;
            go_prev  <= 1'b1;
        end else begin
            key_prev <= bus.key_press;
            go_prev  <= bus.go;
        end
    end

    // Buffer storage (contents need no reset; pointers define validity).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.char_in[4:0];
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Rotor position and head letter; the rotor steps before each encode.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q  <= '0;
            head_q <= '0;
        end else if (start) begin
            pos_q <= bus.rotor_start;
        end else if (fetch) begin
            head_q <= mem[rd_ptr];
            pos_q  <= (pos_q == letter_t'(LETTERS - 1)) ? '0 : pos_q + 1'b1;
        end
    end

    // Sticky capture error flags, cleared by an accepted go edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else if (start) begin
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            if (wr_full) overflow_q <= 1'b1;
            if (wr_bad)  bad_q      <= 1'b1;
        end
    end

    // Output stream register: char_out holds until the consumer accepts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            char_q  <= '0;
            valid_q <= 1'b0;
        end else if (pop) begin
            char_q  <= CW'(path_out);
            valid_q <= 1'b1;
        end else if (ack) begin
            valid_q <= 1'b0;
        end
    end

    // Busy/done status; both update as the FSM leaves DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (start)       busy_q <= 1'b1;
            else if (finish) busy_q <= 1'b0;
        end
    end

    assign bus.char_out  = char_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.bad_char  = bad_q;

endmodule

// File: doc/enigma_stream_decoder.md
Name: enigma_stream_decoder

Overview:
- Receive-side partner of the bombe. The operator types ciphertext letters on the switch/key interface and they are buffered here.
- Once the bombe has deduced a rotor start position, a `go` pulse replays the buffer through a single-rotor-plus-reflector Enigma path.
- Each plaintext letter is emitted on a valid/ready stream for HEX/LED display logic.
- Sits beside the bombe under the top level and shares its char/key/go signalling.

Parameters:
- DEPTH, 16, message buffer entries (power of 2, ≥2).
- CW, 8, character width; letters are indices 0..25 (A=0).

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- resetn  in  1  asynchronous active-low reset
- char_in  in  CW  ciphertext letter index
- key_press  in  1  level, active-high (top inverts KEY); rising edge writes char_in
- go  in  1  level, active-high; rising edge starts a decode
- rotor_start  in  5  rotor start position 0..25 (from bombe)
- char_out  out  CW  plaintext letter index
- out_valid  out  1  char_out valid
- out_ready  in  1  consumer accepts char_out
- busy  out  1  decode in progress
- done  out  1  one-cycle pulse at end of decode
- count  out  $clog2(DEPTH)+1  letters currently buffered
- overflow  out  1  sticky: write dropped because buffer full
- bad_char  out  1  sticky: write dropped because char_in > 25

Behaviour:
- Reset (async assert, sync release) clears:
  - buffer pointers, count, overflow, bad_char
  - char_out=0, out_valid=0, busy=0, done=0
  - edge-detect registers (treat previous level as 1, so a key held through reset does not write)
  - FSM=IDLE
- Capture, IDLE only:
  - Rising edge of key_press writes char_in at the write pointer; count+1 one cycle later.
  - char_in > 25 → no write, bad_char=1.
  - count==DEPTH → no write, overflow=1.
  - Key edges outside IDLE are ignored; nothing is queued.
- Decode FSM: IDLE → FETCH → XLATE → EMIT → (FETCH | DONE) → IDLE.
  - IDLE: on a rising edge of go, latch p=rotor_start, busy=1. If count==0, go straight to DONE. go edges while busy are ignored. Sticky flags clear on a go edge.
  - FETCH: read the head entry and step the rotor before encoding: p ← (p==25) ? 0 : p+1.
  - XLATE: register the result into char_out and pop the entry (count−1).
  - EMIT: out_valid=1; char_out is held stable until out_ready. On out_valid&&out_ready, go to FETCH if count>0, else DONE.
    - Latency from go edge to first out_valid is 3 cycles; with out_ready held high, one letter every 3 cycles.
  - DONE: done=1 for one cycle, busy=0, then IDLE. The buffer is empty after a decode.
- Letter path, all arithmetic mod 26 on 5-bit values, with explicit wrap (never raw 5-bit overflow), for x=letter and p=position:
  - a=(x+p)
  - b=ROTOR_I[a]
  - d=(b−p)
  - e=REFL_B[d]
  - f=(e+p)
  - g=ROTOR_I_INV[f]
  - out=(g−p)
  - The path is self-inverse: the same block encrypts.
- Tables:
  - ROTOR_I = EKMFLGDQVZNTOWYHXUSPAIBRCJ
  - REFL_B = YRUHQSLDPXNGOKMIEBFZCWVJAT
- resetn asserted mid-decode aborts immediately. No done pulse; the buffer is lost.

Optional Feature:
- Macro: ENIGMA_PLUGBOARD_EN.
- Defined: a fixed plugboard swap is applied to x before step a and to out after the last step.
  - Pairs from package PLUG_PAIRS: A↔B, C↔D, E↔F.
  - The path remains self-inverse; FETCH→XLATE latency is unchanged.
- Undefined: plugboard is identity, with no extra logic.

Decomposition:
- Package enigma_pkg holds:
  - LETTERS=26
  - ROTOR_I, ROTOR_I_INV, REFL_B as 26-entry 5-bit constant arrays
  - PLUG_PAIRS
  - letter_t (5-bit)
  - decoder state enum
  - mod26_add / mod26_sub functions
- One sub-module: enigma_letter_path, combinational x,p → out, including the optional plugboard. It is reusable by the bombe and the encrypt path.
- Buffer, edge detect and FSM stay in the top of this block.

Test Plan:
- Reset, then press A,A (0,0), rotor_start=0, go, out_ready=1 → char_out 13 (N) then 17 (R), done pulse; count 2→0.
- Press N (13), rotor_start=0, go → out 0 (A); confirms self-inverse.
- rotor_start=25, press A, go → first step wraps p to 0; out = path(0,0) from the table model. Also check go with empty buffer gives done 2 cycles later with no out_valid.
- Fill DEPTH+1 presses → count=16, overflow=1, 17th letter never emitted. char_in=30 → bad_char=1, count unchanged.
- out_ready low for 5 cycles during EMIT → out_valid and char_out stable; key presses and go edges during busy are ignored.
- Assert resetn low mid-EMIT → all outputs 0 asynchronously, FSM IDLE, count 0. With ENIGMA_PLUGBOARD_EN, the A,A vector yields the model value.
